// File: rtl/msk_tx_mod_if.sv
// Bit-source handshake plus I/Q sample stream of the MSK modulator.
// The master drives bits in and consumes samples; the slave is the modulator.
interface msk_tx_mod_if #(
  parameter int WO = 16
);
  logic                 bit_i;
  logic                 bit_val_i;
  logic                 bit_rdy_o;
  logic signed [WO-1:0] i_o;
  logic signed [WO-1:0] q_o;
  logic                 iq_val_o;
  logic                 sym_valid_o;
  logic                 underflow_o;

  modport master (
    output bit_i, bit_val_i,
    input  bit_rdy_o, i_o, q_o, iq_val_o, sym_valid_o, underflow_o
  );

  modport slave (
    input  bit_i, bit_val_i,
    output bit_rdy_o, i_o, q_o, iq_val_o, sym_valid_o, underflow_o
  );
endinterface

// File: rtl/msk_tx_mod.sv
// Continuous-phase MSK modulator: a phase index walks +/-1 per sample around a
// 4*OSF circle and addresses cos/sin tables; one queued bit keeps symbols back-to-back.
module msk_tx_mod #(
  parameter int OSF      = 20,
  parameter int WO       = 16,
  parameter int AMP      = 2**(WO-1)-1,
  parameter int DIFF_ENC = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         samp_en_i,
  msk_tx_mod_if.slave  bus
);
  localparam int NP = 4*OSF;
  localparam int PW = $clog2(NP);
  localparam int CW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam logic [PW-1:0] P_MAX    = PW'(NP-1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSF-1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam real PI = 3.14159265358979323846;

  function automatic logic signed [WO-1:0] f_lut(input int p, input bit is_sin);
    real a;
    real r;
    int  v;
    a = 2.0 * PI * p / NP;
    r = AMP * (is_sin ? $sin(a) : $cos(a));
    r = (r >= 0.0) ? $floor(r + 0.5) : $ceil(r - 0.5);
    v = $rtoi(r);
    if (v > AMP)       v = AMP;
    else if (v < -AMP) v = -AMP;
    return v[WO-1:0];
  endfunction

  // Table inputs are genvars only, so each entry folds to a constant.
  logic signed [WO-1:0] w_cos [NP];
  logic signed [WO-1:0] w_sin [NP];
  for (genvar g = 0; g < NP; g++) begin : g_lut
    assign w_cos[g] = f_lut(g, 1'b0);
    assign w_sin[g] = f_lut(g, 1'b1);
  end

  logic [0:0]           r_state;
  logic [PW-1:0]        r_p;
  logic [CW-1:0]        r_cnt;
  logic                 r_cur, r_nxt, r_nxt_full, r_dprev, r_rdy;
  logic signed [WO-1:0] r_i, r_q;
  logic                 r_iqv, r_sym, r_uf;

  logic          w_acc, w_load, w_nxt_full_d, w_d, w_last;
  logic [PW-1:0] w_p_nxt;

  assign w_last       = (r_cnt == CNT_LAST);
  assign w_acc        = bus.bit_val_i & r_rdy;
  assign w_load       = samp_en_i & r_nxt_full & ((r_state == S_IDLE) | w_last);
  assign w_nxt_full_d = w_acc | (r_nxt_full & ~w_load);
  assign w_d          = (DIFF_ENC != 0) ? (r_nxt ^ r_dprev) : r_nxt;
  assign w_p_nxt      = r_cur ? ((r_p == P_MAX) ? '0 : r_p + 1'b1)
                              : ((r_p == '0) ? P_MAX : r_p - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_cnt      <= '0;
      r_cur      <= 1'b0;
      r_nxt      <= 1'b0;
      r_nxt_full <= 1'b0;
      r_dprev    <= 1'b0;
      r_rdy      <= 1'b1;
      r_i        <= '0;
      r_q        <= '0;
      r_iqv      <= 1'b0;
      r_sym      <= 1'b0;
      r_uf       <= 1'b0;
    end else begin
      r_iqv      <= 1'b0;
      r_sym      <= 1'b0;
      r_uf       <= 1'b0;
      // Ready is the registered complement of next cycle's fullness.
      r_nxt_full <= w_nxt_full_d;
      r_rdy      <= ~w_nxt_full_d;
      if (w_acc) r_nxt <= bus.bit_i;
      if (w_load) begin
        r_cur   <= w_d;
        r_dprev <= w_d;
      end
      if (samp_en_i) begin
        if (r_state == S_IDLE) begin
          if (r_nxt_full) begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end else begin
          r_i   <= w_cos[r_p];
          r_q   <= w_sin[r_p];
          r_iqv <= 1'b1;
          r_sym <= (r_cnt == '0);
          r_p   <= w_p_nxt;
          if (w_last) begin
            r_cnt <= '0;
            if (!r_nxt_full) begin
              r_state <= S_IDLE;
              r_uf    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.bit_rdy_o   = r_rdy;
  assign bus.i_o         = r_i;
  assign bus.q_o         = r_q;
  assign bus.iq_val_o    = r_iqv;
  assign bus.sym_valid_o = r_sym;
  assign bus.underflow_o = r_uf;
endmodule

// File: tb/tb_msk_tx_mod.sv
// Bench for msk_tx_mod: directed phases with random bits/handshake, checked
// against a phase-accumulation model of the ideal MSK waveform.
module tb_msk_tx_mod;
  localparam int  OSF = 20;
  localparam int  WO  = 16;
  localparam int  NP  = 4*OSF;
  localparam real PI  = 3.14159265358979323846;

  typedef struct {
    int i;
    int q;
    bit sym;
    bit uf;
    int en;
  } smp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  msk_tx_mod_if #(.WO(WO)) b0 ();
  msk_tx_mod_if #(.WO(WO)) b1 ();

  msk_tx_mod #(.OSF(OSF), .WO(WO), .DIFF_ENC(0)) u0 (
    .clk(clk), .reset_n(reset_n), .samp_en_i(en0), .bus(b0));
  msk_tx_mod #(.OSF(OSF), .WO(WO), .DIFF_ENC(1)) u1 (
    .clk(clk), .reset_n(reset_n), .samp_en_i(en1), .bus(b1));

  logic                 m_rdy, m_val, m_bit, m_en, m_iqv, m_sym, m_uf;
  logic signed [WO-1:0] m_i, m_q;
  assign m_rdy = sel ? b1.bit_rdy_o   : b0.bit_rdy_o;
  assign m_val = sel ? b1.bit_val_i   : b0.bit_val_i;
  assign m_bit = sel ? b1.bit_i       : b0.bit_i;
  assign m_en  = sel ? en1            : en0;
  assign m_iqv = sel ? b1.iq_val_o    : b0.iq_val_o;
  assign m_sym = sel ? b1.sym_valid_o : b0.sym_valid_o;
  assign m_uf  = sel ? b1.underflow_o : b0.underflow_o;
  assign m_i   = sel ? b1.i_o         : b0.i_o;
  assign m_q   = sel ? b1.q_o         : b0.q_o;

  int   total = 0, bad = 0;
  int   en_cnt = 0, stray_uf = 0;
  bit   acc_prev = 1'b0;
  bit   acc_q[$];
  smp_t smp[$];
  int   mp = 0;
  bit   mdp = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_amp(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction
  function automatic int ecos(input int p);
    return rnd_amp(32767.0 * $cos(2.0 * PI * p / NP));
  endfunction
  function automatic int esin(input int p);
    return rnd_amp(32767.0 * $sin(2.0 * PI * p / NP));
  endfunction

  always @(posedge clk) begin
    acc_prev = 1'b0;
    if (reset_n) begin
      if (m_en) en_cnt++;
      acc_prev = m_val && m_rdy;
      if (acc_prev) acc_q.push_back(m_bit);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_iqv) smp.push_back('{int'(m_i), int'(m_q), m_sym, m_uf, en_cnt});
      else if (m_uf) stray_uf++;
      if (acc_prev) chk("rdy_low_after_accept", int'(m_rdy), 0);
    end
  end

  task automatic drive(input bit en, input bit val, input bit b);
    if (sel) begin
      en1 = en; b1.bit_val_i = val; b1.bit_i = b;
    end else begin
      en0 = en; b0.bit_val_i = val; b0.bit_i = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_i", int'(m_i), 0);
    chk("rst_q", int'(m_q), 0);
    chk("rst_iqv", int'(m_iqv), 0);
    chk("rst_sym", int'(m_sym), 0);
    chk("rst_uf", int'(m_uf), 0);
    chk("rst_rdy", int'(m_rdy), 1);
    reset_n = 1'b1;
    acc_q.delete();
    smp.delete();
    stray_uf = 0;
    mp  = 0;
    mdp = 1'b0;
  endtask

  // Offer src bits (optionally with random valid gaps), then drain all samples.
  task automatic run(input bit src[$], input int period, input bit rnd);
    int c = 0;
    int k;
    int target = src.size() * OSF;
    forever begin
      @(negedge clk);
      k = acc_q.size();
      if (k >= src.size() || c > 4000) break;
      drive(c % period == 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, src[k]);
      c++;
    end
    drive(c % period == 0, 1'b0, 1'b0);
    while (smp.size() < target && c < 8000) begin
      @(negedge clk);
      c++;
      drive(c % period == 0, 1'b0, 1'b0);
    end
    repeat (3 * period + 3) begin
      @(negedge clk);
      c++;
      drive(c % period == 0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("accepted_count", acc_q.size(), src.size());
    for (int j = 0; j < src.size() && j < acc_q.size(); j++)
      chk("accepted_bit", int'(acc_q[j]), int'(src[j]));
  endtask

  // Expected waveform: each symbol sweeps +/-OSF indices from the previous end phase.
  task automatic check_stream(input bit diff);
    int  n = acc_q.size();
    bit  d;
    int  idx, pe;
    bit  cont;
    chk("num_samples", smp.size(), n * OSF);
    chk("stray_underflow", stray_uf, 0);
    for (int s = 0; s < n; s++) begin
      d   = diff ? (acc_q[s] ^ mdp) : acc_q[s];
      mdp = d;
      for (int k = 0; k < OSF; k++) begin
        idx = s * OSF + k;
        pe  = ((mp + (d ? k : -k)) % NP + NP) % NP;
        if (idx < smp.size()) begin
          chk("sample_i", smp[idx].i, ecos(pe));
          chk("sample_q", smp[idx].q, esin(pe));
          chk("sym_valid", int'(smp[idx].sym), int'(k == 0));
          cont = (s + 1 < n) && (idx + 1 < smp.size()) && (smp[idx + 1].en == smp[idx].en + 1);
          chk("underflow", int'(smp[idx].uf), int'(k == OSF - 1 && !cont));
        end
      end
      mp = ((mp + (d ? OSF : -OSF)) % NP + NP) % NP;
    end
    acc_q.delete();
    smp.delete();
    stray_uf = 0;
  endtask

  initial begin
    bit s[$];
    int ufs;
    drive(1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    sel = 1'b0;

    do_reset();

    s = '{1'b1};
    run(s, 1, 1'b0);
    if (smp.size() >= OSF) begin
      chk("b1_first_i", smp[0].i, 32767);
      chk("b1_first_q", smp[0].q, 0);
      chk("b1_11th_i", smp[10].i, 23170);
      chk("b1_11th_q", smp[10].q, 23170);
      chk("b1_last_uf", int'(smp[OSF-1].uf), 1);
    end else chk("b1_sample_count", smp.size(), OSF);
    check_stream(1'b0);

    s = '{1'b0, 1'b1};
    run(s, 1, 1'b0);
    if (smp.size() > 0) begin
      chk("held_p20_i", smp[0].i, 0);
      chk("held_p20_q", smp[0].q, 32767);
    end
    check_stream(1'b0);

    do_reset();
    s = '{1'b0};
    run(s, 1, 1'b0);
    if (smp.size() >= 2) begin
      chk("b0_2nd_i", smp[1].i, 32666);
      chk("b0_2nd_q", smp[1].q, -2571);
    end
    check_stream(1'b0);

    do_reset();
    s = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(s, 1, 1'b0);
    if (smp.size() == 8 * OSF) chk("eight_contiguous", smp[8*OSF-1].en - smp[0].en, 8 * OSF - 1);
    check_stream(1'b0);

    s.delete();
    for (int j = 0; j < 12; j++) s.push_back(1'($urandom_range(0, 1)));
    run(s, 3, 1'b1);
    check_stream(1'b0);

    // Abort a symbol with reset part way through.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    ufs = 0;
    foreach (smp[j]) ufs += int'(smp[j].uf);
    chk("abort_no_uf_before", ufs + stray_uf, 0);
    do_reset();
    repeat (OSF + 5) @(negedge clk);
    chk("abort_no_uf_after", stray_uf, 0);
    chk("abort_no_samples", smp.size(), 0);
    s = '{1'b1};
    run(s, 1, 1'b0);
    if (smp.size() > 0) begin
      chk("restart_i", smp[0].i, 32767);
      chk("restart_q", smp[0].q, 0);
    end
    check_stream(1'b0);

    sel = 1'b1;
    do_reset();
    s = '{1'b1, 1'b1};
    run(s, 1, 1'b0);
    if (smp.size() == 2 * OSF) begin
      chk("diff_sym2_i", smp[OSF].i, ecos(20));
      chk("diff_sym2_q", smp[OSF].q, esin(20));
      chk("diff_sym2_dn_i", smp[OSF+1].i, ecos(19));
      chk("diff_last_i", smp[2*OSF-1].i, ecos(1));
      chk("diff_last_q", smp[2*OSF-1].q, esin(1));
    end
    check_stream(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
